// File: rtl/id_operand_stage.sv
// Decode-side operand stage: per-source forwarding mux, one-bubble load-use stall,
// ID/EX register with valid/ready handshake and late WB-load patching of held operands.
module id_operand_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_inst_i,
    input  logic [4:0]      if_rs1_addr_i,
    input  logic [4:0]      if_rs2_addr_i,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic [XLEN-1:0] rf_rs2_data_i,
    input  logic [1:0]      if_rs1_foward_type_i,
    input  logic [1:0]      if_rs2_foward_type_i,
    input  logic [XLEN-1:0] ex_rd_data_i,
    input  logic [XLEN-1:0] mem_rd_data_i,
    input  logic [XLEN-1:0] wb_rd_data_i,
    input  logic            ex_inst_is_load_i,
    input  logic            load_forward_rs1_en_i,
    input  logic            load_forward_rs2_en_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_inst_o,
    output logic [4:0]      id_rs1_addr_o,
    output logic [4:0]      id_rs2_addr_o,
    output logic [XLEN-1:0] id_rs1_data_o,
    output logic [XLEN-1:0] id_rs2_data_o,
    output logic            load_stall_o,
    output logic [31:0]     lu_stall_cnt_o
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] LU_STALL = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } idex_t;

    logic [0:0]  state;
    logic        id_valid;
    idex_t       idex_q;
    idex_t       idex_d;
    logic [31:0] lu_cnt;
    logic        hazard;
    logic        fire;
    logic        stall_issue;
    logic        patch_rs1;
    logic        patch_rs2;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      addr,
        input logic [1:0]      typ,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] ex,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb
    );
        logic [XLEN-1:0] r;
        case (typ)
            2'b01:   r = ex;
            2'b11:   r = mem;
            2'b10:   r = wb;
            default: r = rf;
        endcase
        if (addr == 5'd0) r = '0;
        return r;
    endfunction

    // Both sources count as used: conservative, no decode of the opcode here.
    assign hazard = if_valid_i && (state == RUN) && ex_inst_is_load_i &&
                    (if_rs1_foward_type_i == 2'b01 || if_rs2_foward_type_i == 2'b01);

    assign if_ready_o   = (!id_valid || ex_ready_i) && !hazard && !flush_i;
    assign fire         = if_valid_i && if_ready_o;
    assign stall_issue  = hazard && (!id_valid || ex_ready_i);
    assign load_stall_o = hazard && rst_n;

    // Patching only happens while held, so it never coincides with a fire.
    assign patch_rs1 = id_valid && !ex_ready_i && load_forward_rs1_en_i && (idex_q.rs1_addr != 5'd0);
    assign patch_rs2 = id_valid && !ex_ready_i && load_forward_rs2_en_i && (idex_q.rs2_addr != 5'd0);

    always_comb begin
        idex_d          = idex_q;
        idex_d.pc       = if_pc_i;
        idex_d.inst     = if_inst_i;
        idex_d.rs1_addr = if_rs1_addr_i;
        idex_d.rs2_addr = if_rs2_addr_i;
        idex_d.rs1_data = fwd_sel(if_rs1_addr_i, if_rs1_foward_type_i, rf_rs1_data_i,
                                  ex_rd_data_i, mem_rd_data_i, wb_rd_data_i);
        idex_d.rs2_data = fwd_sel(if_rs2_addr_i, if_rs2_foward_type_i, rf_rs2_data_i,
                                  ex_rd_data_i, mem_rd_data_i, wb_rd_data_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            id_valid <= 1'b0;
            idex_q   <= '0;
            lu_cnt   <= '0;
        end else if (flush_i) begin
            id_valid <= 1'b0;
            state    <= RUN;
        end else begin
            if (fire) begin
                id_valid <= 1'b1;
                idex_q   <= idex_d;
            end else if (ex_ready_i && id_valid) begin
                id_valid <= 1'b0;
            end
            if (patch_rs1) idex_q.rs1_data <= wb_rd_data_i;
            if (patch_rs2) idex_q.rs2_data <= wb_rd_data_i;
            // One-cycle stall: by the next cycle the load sits in MEM.
            if (state == LU_STALL) begin
                state <= RUN;
            end else if (stall_issue) begin
                state <= LU_STALL;
                if (lu_cnt != 32'hFFFF_FFFF) lu_cnt <= lu_cnt + 32'd1;
            end
        end
    end

    assign id_valid_o     = id_valid;
    assign id_pc_o        = idex_q.pc;
    assign id_inst_o      = idex_q.inst;
    assign id_rs1_addr_o  = idex_q.rs1_addr;
    assign id_rs2_addr_o  = idex_q.rs2_addr;
    assign id_rs1_data_o  = idex_q.rs1_data;
    assign id_rs2_data_o  = idex_q.rs2_data;
    assign lu_stall_cnt_o = lu_cnt;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: vector table, directed multi-cycle sequences and
// a randomized run against a cycle-level behavioural model.
module tb_id_operand_stage;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid_i;
    logic            if_ready_o;
    logic [XLEN-1:0] if_pc_i;
    logic [31:0]     if_inst_i;
    logic [4:0]      if_rs1_addr_i, if_rs2_addr_i;
    logic [XLEN-1:0] rf_rs1_data_i, rf_rs2_data_i;
    logic [1:0]      if_rs1_foward_type_i, if_rs2_foward_type_i;
    logic [XLEN-1:0] ex_rd_data_i, mem_rd_data_i, wb_rd_data_i;
    logic            ex_inst_is_load_i;
    logic            load_forward_rs1_en_i, load_forward_rs2_en_i;
    logic            flush_i, ex_ready_i;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [31:0]     id_inst_o;
    logic [4:0]      id_rs1_addr_o, id_rs2_addr_o;
    logic [XLEN-1:0] id_rs1_data_o, id_rs2_data_o;
    logic            load_stall_o;
    logic [31:0]     lu_stall_cnt_o;

    int tests = 0;
    int fails = 0;

    id_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
        .if_rs1_addr_i(if_rs1_addr_i), .if_rs2_addr_i(if_rs2_addr_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .if_rs1_foward_type_i(if_rs1_foward_type_i), .if_rs2_foward_type_i(if_rs2_foward_type_i),
        .ex_rd_data_i(ex_rd_data_i), .mem_rd_data_i(mem_rd_data_i), .wb_rd_data_i(wb_rd_data_i),
        .ex_inst_is_load_i(ex_inst_is_load_i),
        .load_forward_rs1_en_i(load_forward_rs1_en_i), .load_forward_rs2_en_i(load_forward_rs2_en_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_rs1_addr_o(id_rs1_addr_o), .id_rs2_addr_o(id_rs2_addr_o),
        .id_rs1_data_o(id_rs1_data_o), .id_rs2_data_o(id_rs2_data_o),
        .load_stall_o(load_stall_o), .lu_stall_cnt_o(lu_stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_valid_i = 0; if_pc_i = '0; if_inst_i = '0;
        if_rs1_addr_i = 0; if_rs2_addr_i = 0;
        rf_rs1_data_i = '0; rf_rs2_data_i = '0;
        if_rs1_foward_type_i = 0; if_rs2_foward_type_i = 0;
        ex_rd_data_i = '0; mem_rd_data_i = '0; wb_rd_data_i = '0;
        ex_inst_is_load_i = 0; load_forward_rs1_en_i = 0; load_forward_rs2_en_i = 0;
        flush_i = 0; ex_ready_i = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    // Reference operand selection written from the source-code table.
    function automatic logic [63:0] ref_op(input logic [4:0] a, input logic [1:0] t,
                                           input logic [63:0] rf, ex, mem, wb);
        if (a == 0) return 64'd0;
        if (t == 2'b00) return rf;
        if (t == 2'b01) return ex;
        if (t == 2'b11) return mem;
        return wb;
    endfunction

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [1:0]  t1, t2;
        logic [63:0] rf1, rf2, ex, mem, wb;
        logic        ld;
        logic        e_rdy, e_stall, e_vld;
        logic [63:0] e_d1, e_d2;
    } vec_t;

    vec_t vecs[7];

    // Behavioural model state
    bit          m_valid, m_stalled;
    logic [31:0] m_cnt;
    logic [63:0] m_pc, m_d1, m_d2;
    logic [31:0] m_inst;
    logic [4:0]  m_a1, m_a2;

    initial begin
        rst_n = 0;
        idle_inputs();
        #2;
        chk("reset_valid", id_valid_o, 0);
        chk("reset_cnt", lu_stall_cnt_o, 0);
        chk("reset_pc", id_pc_o, 0);
        chk("reset_stall", load_stall_o, 0);
        rst_n = 1;

        // rs1, rs2, t1, t2, rf1, rf2, ex, mem, wb, ld, ready, stall, valid, d1, d2
        vecs[0] = '{5'd5, 5'd6, 2'b00, 2'b01, 64'h11, 64'h99, 64'h22, 64'h33, 64'h44, 1'b0, 1'b1, 1'b0, 1'b1, 64'h11, 64'h22};
        vecs[1] = '{5'd0, 5'd2, 2'b10, 2'b10, 64'h1, 64'h2, 64'h3, 64'h4, 64'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'hFF};
        vecs[2] = '{5'd1, 5'd0, 2'b11, 2'b11, 64'h1, 64'h2, 64'h3, 64'h33, 64'h5, 1'b0, 1'b1, 1'b0, 1'b1, 64'h33, 64'h0};
        vecs[3] = '{5'd4, 5'd9, 2'b01, 2'b00, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
        vecs[4] = '{5'd3, 5'd0, 2'b00, 2'b01, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
        vecs[5] = '{5'd8, 5'd9, 2'b10, 2'b11, 64'h1, 64'h2, 64'h3, 64'h77, 64'h66, 1'b1, 1'b1, 1'b0, 1'b1, 64'h66, 64'h77};
        vecs[6] = '{5'd31, 5'd30, 2'b00, 2'b00, 64'hAAAA, 64'hBBBB, 64'h3, 64'h4, 64'h5, 1'b0, 1'b1, 1'b0, 1'b1, 64'hAAAA, 64'hBBBB};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            idle_inputs();
            if_valid_i = 1; if_pc_i = 64'h1000 + 64'(i); if_inst_i = 32'h13 + 32'(i);
            if_rs1_addr_i = vecs[i].rs1; if_rs2_addr_i = vecs[i].rs2;
            if_rs1_foward_type_i = vecs[i].t1; if_rs2_foward_type_i = vecs[i].t2;
            rf_rs1_data_i = vecs[i].rf1; rf_rs2_data_i = vecs[i].rf2;
            ex_rd_data_i = vecs[i].ex; mem_rd_data_i = vecs[i].mem; wb_rd_data_i = vecs[i].wb;
            ex_inst_is_load_i = vecs[i].ld;
            #1;
            chk($sformatf("vec%0d_ready", i), if_ready_o, vecs[i].e_rdy);
            chk($sformatf("vec%0d_stall", i), load_stall_o, vecs[i].e_stall);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), id_valid_o, vecs[i].e_vld);
            chk($sformatf("vec%0d_d1", i), id_rs1_data_o, vecs[i].e_d1);
            chk($sformatf("vec%0d_d2", i), id_rs2_data_o, vecs[i].e_d2);
        end

        // Load-use: bubble, then capture the MEM-forwarded value.
        do_reset();
        idle_inputs();
        if_valid_i = 1; if_rs1_addr_i = 3; if_rs1_foward_type_i = 2'b01; ex_inst_is_load_i = 1;
        #1;
        chk("lu_stall_c0", load_stall_o, 1);
        chk("lu_ready_c0", if_ready_o, 0);
        @(posedge clk); #1;
        chk("lu_valid_c1", id_valid_o, 0);
        chk("lu_cnt", lu_stall_cnt_o, 1);
        @(negedge clk);
        if_rs1_foward_type_i = 2'b11; mem_rd_data_i = 64'hAB;
        #1;
        chk("lu_masked", load_stall_o, 0);
        chk("lu_ready_c1", if_ready_o, 1);
        @(posedge clk); #1;
        chk("lu_valid_c2", id_valid_o, 1);
        chk("lu_d1", id_rs1_data_o, 64'hAB);
        chk("lu_cnt_hold", lu_stall_cnt_o, 1);

        // Backpressure hold and late patch.
        do_reset();
        idle_inputs();
        if_valid_i = 1; if_pc_i = 64'h100; if_inst_i = 32'hDEAD;
        if_rs1_addr_i = 0; if_rs2_addr_i = 7; rf_rs2_data_i = 64'h55;
        @(posedge clk); #1;
        chk("bp_cap", id_rs2_data_o, 64'h55);
        @(negedge clk);
        ex_ready_i = 0; if_pc_i = 64'h200; if_inst_i = 32'hBEEF; rf_rs2_data_i = 64'h66;
        #1;
        chk("bp_ready", if_ready_o, 0);
        @(posedge clk); #1;
        chk("bp_hold_pc", id_pc_o, 64'h100);
        chk("bp_hold_d2", id_rs2_data_o, 64'h55);
        @(negedge clk);
        load_forward_rs2_en_i = 1; load_forward_rs1_en_i = 1; wb_rd_data_i = 64'h1234;
        @(posedge clk); #1;
        chk("patch_d2", id_rs2_data_o, 64'h1234);
        chk("patch_x0", id_rs1_data_o, 0);
        chk("patch_pc", id_pc_o, 64'h100);
        chk("patch_inst", id_inst_o, 32'hDEAD);
        chk("patch_valid", id_valid_o, 1);

        // Flush while in LU_STALL wins over the pending capture.
        do_reset();
        idle_inputs();
        if_valid_i = 1; if_rs1_addr_i = 2; if_rs1_foward_type_i = 2'b01; ex_inst_is_load_i = 1;
        @(negedge clk);
        if_rs1_foward_type_i = 2'b11; flush_i = 1;
        #1;
        chk("fl_ready", if_ready_o, 0);
        @(posedge clk); #1;
        chk("fl_valid", id_valid_o, 0);
        @(negedge clk);
        flush_i = 0; if_rs1_foward_type_i = 2'b01;
        #1;
        chk("fl_run", load_stall_o, 1);

        // Counter saturation, then asynchronous reset mid-operation.
        do_reset();
        idle_inputs();
        force dut.lu_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.lu_cnt;
        if_valid_i = 1; if_pc_i = 64'h8000; if_rs1_addr_i = 1;
        if_rs1_foward_type_i = 2'b01; ex_inst_is_load_i = 1;
        @(posedge clk); #1;
        chk("sat_cnt", lu_stall_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        if_rs1_foward_type_i = 2'b11; mem_rd_data_i = 64'h77;
        @(posedge clk); #1;
        chk("sat_valid", id_valid_o, 1);
        @(negedge clk);
        if_rs1_foward_type_i = 2'b01; ex_ready_i = 0;
        #1;
        rst_n = 0;
        #1;
        chk("arst_valid", id_valid_o, 0);
        chk("arst_cnt", lu_stall_cnt_o, 0);
        chk("arst_pc", id_pc_o, 0);
        chk("arst_d1", id_rs1_data_o, 0);
        chk("arst_stall", load_stall_o, 0);
        #1;
        rst_n = 1;
        #1;
        chk("arst_run", load_stall_o, 1);

        // Randomized run against the behavioural model.
        do_reset();
        idle_inputs();
        m_valid = 0; m_stalled = 0; m_cnt = 0;
        m_pc = 0; m_inst = 0; m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0;
        for (int c = 0; c < 400; c++) begin
            bit haz, rdy, fire, nv, ns;
            logic [31:0] nc;
            @(negedge clk);
            if_valid_i = ($urandom_range(0, 9) < 8);
            if_pc_i = {$urandom, $urandom}; if_inst_i = $urandom;
            if_rs1_addr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if_rs2_addr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if_rs1_foward_type_i = 2'($urandom); if_rs2_foward_type_i = 2'($urandom);
            rf_rs1_data_i = {$urandom, $urandom}; rf_rs2_data_i = {$urandom, $urandom};
            ex_rd_data_i = {$urandom, $urandom}; mem_rd_data_i = {$urandom, $urandom};
            wb_rd_data_i = {$urandom, $urandom};
            ex_inst_is_load_i = ($urandom_range(0, 9) < 4);
            load_forward_rs1_en_i = ($urandom_range(0, 9) < 3);
            load_forward_rs2_en_i = ($urandom_range(0, 9) < 3);
            flush_i = ($urandom_range(0, 19) == 0);
            ex_ready_i = ($urandom_range(0, 9) < 7);
            #1;
            haz = if_valid_i && !m_stalled && ex_inst_is_load_i &&
                  (if_rs1_foward_type_i == 2'b01 || if_rs2_foward_type_i == 2'b01);
            rdy = (!m_valid || ex_ready_i) && !haz && !flush_i;
            fire = if_valid_i && rdy;
            chk($sformatf("rnd%0d_ready", c), if_ready_o, rdy);
            chk($sformatf("rnd%0d_stall", c), load_stall_o, haz);
            nv = m_valid; ns = m_stalled; nc = m_cnt;
            if (flush_i) begin
                nv = 0; ns = 0;
            end else begin
                if (fire) begin
                    nv = 1; m_pc = if_pc_i; m_inst = if_inst_i;
                    m_a1 = if_rs1_addr_i; m_a2 = if_rs2_addr_i;
                    m_d1 = ref_op(if_rs1_addr_i, if_rs1_foward_type_i, rf_rs1_data_i,
                                  ex_rd_data_i, mem_rd_data_i, wb_rd_data_i);
                    m_d2 = ref_op(if_rs2_addr_i, if_rs2_foward_type_i, rf_rs2_data_i,
                                  ex_rd_data_i, mem_rd_data_i, wb_rd_data_i);
                end else if (ex_ready_i && m_valid) begin
                    nv = 0;
                end
                if (m_valid && !ex_ready_i && load_forward_rs1_en_i && m_a1 != 0) m_d1 = wb_rd_data_i;
                if (m_valid && !ex_ready_i && load_forward_rs2_en_i && m_a2 != 0) m_d2 = wb_rd_data_i;
                if (m_stalled) ns = 0;
                else if (haz && (!m_valid || ex_ready_i)) begin
                    ns = 1;
                    if (m_cnt != 32'hFFFF_FFFF) nc = m_cnt + 1;
                end
            end
            m_valid = nv; m_stalled = ns; m_cnt = nc;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_valid", c), id_valid_o, m_valid);
            chk($sformatf("rnd%0d_cnt", c), lu_stall_cnt_o, m_cnt);
            if (m_valid) begin
                chk($sformatf("rnd%0d_pc", c), id_pc_o, m_pc);
                chk($sformatf("rnd%0d_inst", c), id_inst_o, m_inst);
                chk($sformatf("rnd%0d_a1", c), id_rs1_addr_o, m_a1);
                chk($sformatf("rnd%0d_a2", c), id_rs2_addr_o, m_a2);
                chk($sformatf("rnd%0d_d1", c), id_rs1_data_o, m_d1);
                chk($sformatf("rnd%0d_d2", c), id_rs2_data_o, m_d2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

- Decode-side operand stage. It sits between the IF/ID register and the EX stage, directly downstream of the forwarding unit.
- For each source register it picks the operand from one of four places, using the forwarding unit's type codes: register file, EX result, MEM result or WB result.
- It inserts a one-bubble load-use stall and registers the instruction into the ID/EX pipeline register with a valid/ready handshake.
- While an instruction is held in ID/EX, it patches held operands with late WB load data.

## Interface
- XLEN, 64, datapath width.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid_i  in  1  IF/ID holds a valid instruction.
- if_ready_o  out  1  this stage accepts the IF/ID instruction this cycle.
- if_pc_i  in  XLEN  instruction PC.
- if_inst_i  in  32  instruction word.
- if_rs1_addr_i, if_rs2_addr_i  in  5 each  source register indices.
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN each  register-file read data.
- if_rs1_foward_type_i, if_rs2_foward_type_i  in  2 each  operand source code:
  - 00 register file
  - 01 EX
  - 11 MEM
  - 10 WB
- ex_rd_data_i, mem_rd_data_i, wb_rd_data_i  in  XLEN each  result bypass buses.
- ex_inst_is_load_i  in  1  the instruction in EX is a load.
- load_forward_rs1_en_i, load_forward_rs2_en_i  in  1 each  a WB load targets the held rs1/rs2.
- flush_i  in  1  branch/trap flush.
- ex_ready_i  in  1  EX accepts the ID/EX contents.
- id_valid_o  out  1  ID/EX holds a valid instruction.
- id_pc_o  out  XLEN  registered PC.
- id_inst_o  out  32  registered instruction.
- id_rs1_addr_o, id_rs2_addr_o  out  5 each  registered source indices.
- id_rs1_data_o, id_rs2_data_o  out  XLEN each  registered operands.
- load_stall_o  out  1  the load-use hazard is blocking IF/ID this cycle.
- lu_stall_cnt_o  out  32  count of load-use bubble cycles.

## Operation
- Operand mux, per source:
  - The type code selects rf, ex, mem or wb data.
  - Address 0 always yields 0, regardless of the type code.
- Hazard condition: if_valid_i, state RUN, ex_inst_is_load_i, and either type code equal to 01.
  - Both sources are treated as used, so the check is conservative.
- Acceptance: if_ready_o = (!id_valid_o || ex_ready_i) && !hazard && !flush_i.
  - A fire is if_valid_i && if_ready_o.
- Capture on fire, at the next edge:
  - id_valid_o <= 1.
  - pc, inst, addresses and muxed operands are registered into ID/EX.
- No fire, while ex_ready_i && id_valid_o: id_valid_o <= 0, which inserts a bubble.
- Otherwise the registers hold.
- FSM states RUN and LU_STALL:
  - RUN -> LU_STALL when hazard && (!id_valid_o || ex_ready_i). The bubble is issued and lu_stall_cnt_o increments.
  - LU_STALL -> RUN after exactly one cycle.
  - In LU_STALL the hazard is masked, because the load has moved to MEM. The capture then takes the MEM-forwarded value, type 11.
  - If hazard holds but EX is stalled, remain in RUN with if_ready_o=0. No count is taken.
- Late patch:
  - Condition: id_valid_o && !ex_ready_i && load_forward_rsN_en_i && id_rsN_addr_o != 0.
  - Action: id_rsN_data_o <= wb_rd_data_i at the edge.
  - rs1 and rs2 are patched independently.
- Flush:
  - At the edge: id_valid_o <= 0 and state <= RUN.
  - That same cycle: if_ready_o = 0.
  - Flush has priority over capture, stall and patch.
  - Data registers may keep stale values.
- lu_stall_cnt_o:
  - Increments on each RUN->LU_STALL transition.
  - Saturates at 0xFFFFFFFF.
  - Is cleared only by reset.

## Timing
- Reset values, all asynchronous:
  - id_valid_o 0; state RUN; lu_stall_cnt_o 0.
  - id_pc_o, id_inst_o, addresses and operands 0.
- load_stall_o = hazard, purely combinational; it is 0 during reset.
- Latency:
  - One cycle from IF/ID fire to id_valid_o.
  - The operand mux is combinational in the fire cycle.
- Handshake:
  - The ID/EX contents remain stable while id_valid_o && !ex_ready_i, except for the late patch.
  - Simultaneous ex_ready_i and fire gives back-to-back transfer with no bubble.
- A load-use instruction reaches id_valid_o two cycles after first being presented, given ex_ready_i held high.
- Reset asserted mid-stall returns the block to RUN immediately and drops id_valid_o.

## Test plan
- Basic capture:
  - Stimulus: rs1=5 with type 00 and rf=0x11; rs2=6 with type 01 and ex=0x22; ex_ready_i=1.
  - Response: one cycle later id_valid_o=1, rs1_data=0x11, rs2_data=0x22.
- Load-use:
  - Stimulus: rs1 type 01 with ex_inst_is_load_i=1.
  - Cycle 0: load_stall_o=1, if_ready_o=0.
  - Next cycle, with type 11 and mem=0xAB: captured rs1_data=0xAB; lu_stall_cnt_o=1.
- x0 source: rs1 addr 0 with type 10 and wb=0xFF -> rs1_data=0.
- Backpressure and patch:
  - Stimulus: hold ex_ready_i=0 with id_rs2_addr_o=7, then pulse load_forward_rs2_en_i with wb=0x1234.
  - Response: rs2_data becomes 0x1234; id_pc_o and id_inst_o are unchanged.
- Flush vs fire:
  - Stimulus: flush_i=1 together with a valid IF/ID instruction while in LU_STALL.
  - Response: if_ready_o=0; next cycle id_valid_o=0 and state RUN.
- Counter and reset:
  - Stimulus: force lu_stall_cnt_o to 0xFFFFFFFF, cause one more stall, then assert rst_n=0 between clock edges.
  - Response: the count stays at 0xFFFFFFFF; the outputs clear without waiting for a clock edge.
